// File: rtl/pc_pkg.sv
// Shared types and constants for the PC successor logic.
package pc_pkg;

    typedef enum logic [1:0] {BOOT, RUN, HALT} pc_state_e;

    localparam logic REDIR_BRANCH = 1'b0;
    localparam logic REDIR_JALR   = 1'b1;

    localparam logic [31:0] DEF_RESET_VECTOR = 32'h0100_0000;
    localparam logic [31:0] DEF_TRAP_VECTOR  = 32'h0100_0100;

    // 16-bit alignment only cares about bit 0; 32-bit alignment needs both low bits clear.
    function automatic logic is_misaligned(input logic [1:0] low_bits, input int ialign);
        return (ialign == 16) ? low_bits[0] : (|low_bits);
    endfunction

endpackage

// File: rtl/pc_target_adder.sv
// base + imm, wrapping mod 2^XLEN, with optional clearing of the LSB (JALR).
module pc_target_adder #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] base,
    input  logic [XLEN-1:0] imm,
    input  logic            clr_lsb,
    output logic [XLEN-1:0] sum
);

    logic [XLEN-1:0] raw;

    assign raw = base + imm;
    assign sum = {raw[XLEN-1:1], raw[0] & ~clr_lsb};

endmodule

// File: rtl/pc_next_unit.sv
// Architectural PC register with fetch handshake, one-entry pending redirect and misalign trap.
module pc_next_unit
    import pc_pkg::*;
#(
    parameter int               XLEN         = 32,
    parameter logic [XLEN-1:0]  RESET_VECTOR = XLEN'(DEF_RESET_VECTOR),
    parameter logic [XLEN-1:0]  TRAP_VECTOR  = XLEN'(DEF_TRAP_VECTOR),
    parameter int               IALIGN       = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall_i,
    output logic            fetch_valid_o,
    input  logic            fetch_ready_i,
    input  logic            redir_valid_i,
    input  logic            redir_sel_i,
    input  logic [XLEN-1:0] redir_pc_i,
    input  logic [XLEN-1:0] imm_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic            trap_clr_i,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_plus4_o,
    output logic            misalign_o,
    output logic [XLEN-1:0] badaddr_o
);

    localparam logic [XLEN-1:0] FOUR = XLEN'(4);

    pc_state_e       state;
    logic            pend_valid;
    logic [XLEN-1:0] pend_tgt;

    logic [XLEN-1:0] br_sum;
    logic [XLEN-1:0] jalr_sum;
    logic [XLEN-1:0] live_tgt;
    logic [XLEN-1:0] next_tgt;
    logic            advance;
    logic            redir_taken;
    logic            tgt_misaligned;

    pc_target_adder #(.XLEN(XLEN)) u_br_add (
        .base    (redir_pc_i),
        .imm     (imm_i),
        .clr_lsb (1'b0),
        .sum     (br_sum)
    );

    pc_target_adder #(.XLEN(XLEN)) u_jalr_add (
        .base    (rs1_i),
        .imm     (imm_i),
        .clr_lsb (1'b1),
        .sum     (jalr_sum)
    );

    pc_target_adder #(.XLEN(XLEN)) u_seq_add (
        .base    (pc_o),
        .imm     (FOUR),
        .clr_lsb (1'b0),
        .sum     (pc_plus4_o)
    );

    assign live_tgt = (redir_sel_i == REDIR_JALR) ? jalr_sum : br_sum;
    assign advance  = (state == RUN) && fetch_valid_o && fetch_ready_i && !stall_i;

    // Live redirect beats the buffered one, which beats sequential fetch.
    assign redir_taken    = redir_valid_i || pend_valid;
    assign next_tgt       = redir_valid_i ? live_tgt : (pend_valid ? pend_tgt : pc_plus4_o);
    assign tgt_misaligned = redir_taken && is_misaligned(next_tgt[1:0], IALIGN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= BOOT;
            pc_o          <= RESET_VECTOR;
            fetch_valid_o <= 1'b0;
            misalign_o    <= 1'b0;
            badaddr_o     <= '0;
            pend_valid    <= 1'b0;
            pend_tgt      <= '0;
        end else begin
            case (state)
                BOOT: begin
                    state         <= RUN;
                    fetch_valid_o <= 1'b1;
                    if (redir_valid_i) begin
                        pend_valid <= 1'b1;
                        pend_tgt   <= live_tgt;
                    end
                end
                RUN: begin
                    if (advance) begin
                        pend_valid <= 1'b0;
                        if (tgt_misaligned) begin
                            state         <= HALT;
                            fetch_valid_o <= 1'b0;
                            misalign_o    <= 1'b1;
                            badaddr_o     <= next_tgt;
                        end else begin
                            pc_o <= next_tgt;
                        end
                    end else if (redir_valid_i) begin
                        pend_valid <= 1'b1;
                        pend_tgt   <= live_tgt;
                    end
                end
                HALT: begin
                    if (trap_clr_i) begin
                        state         <= RUN;
                        fetch_valid_o <= 1'b1;
                        misalign_o    <= 1'b0;
                        pc_o          <= TRAP_VECTOR;
                    end
                end
                default: begin
                    state         <= BOOT;
                    fetch_valid_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_next_unit.sv
// Bench for pc_next_unit: IALIGN=32 and IALIGN=16 instances on shared stimulus, checked against a behavioural model.
module tb_pc_next_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, ready, redir_valid, redir_sel, trap_clr;
    logic [31:0] redir_pc, imm, rs1;

    logic        fv32, mis32, fv16, mis16;
    logic [31:0] pc32, p4_32, bad32, pc16, p4_16, bad16;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pc_next_unit #(.IALIGN(32)) u32 (
        .clk(clk), .rst_n(rst_n), .stall_i(stall), .fetch_valid_o(fv32), .fetch_ready_i(ready),
        .redir_valid_i(redir_valid), .redir_sel_i(redir_sel), .redir_pc_i(redir_pc), .imm_i(imm),
        .rs1_i(rs1), .trap_clr_i(trap_clr), .pc_o(pc32), .pc_plus4_o(p4_32),
        .misalign_o(mis32), .badaddr_o(bad32)
    );

    pc_next_unit #(.IALIGN(16)) u16 (
        .clk(clk), .rst_n(rst_n), .stall_i(stall), .fetch_valid_o(fv16), .fetch_ready_i(ready),
        .redir_valid_i(redir_valid), .redir_sel_i(redir_sel), .redir_pc_i(redir_pc), .imm_i(imm),
        .rs1_i(rs1), .trap_clr_i(trap_clr), .pc_o(pc16), .pc_plus4_o(p4_16),
        .misalign_o(mis16), .badaddr_o(bad16)
    );

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: index 0 is the IALIGN=32 unit, index 1 the IALIGN=16 unit. mode 0=boot 1=run 2=halt.
    int          m_mode [2];
    logic [31:0] m_pc   [2];
    logic [31:0] m_bad  [2];
    bit          m_mis  [2];
    bit          m_has  [2];
    logic [31:0] m_pend [2];

    function automatic bit bad_align(input logic [31:0] t, input int ialign);
        return (ialign == 32) ? ((t % 4) != 0) : ((t % 2) != 0);
    endfunction

    function automatic logic [31:0] live_target();
        return redir_sel ? ((rs1 + imm) & 32'hFFFF_FFFE) : (redir_pc + imm);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                m_mode[k] = 0; m_pc[k] = 32'h0100_0000; m_bad[k] = 0;
                m_mis[k] = 0;  m_has[k] = 0;            m_pend[k] = 0;
            end else begin
                case (m_mode[k])
                    0: begin
                        if (redir_valid) begin m_has[k] = 1; m_pend[k] = live_target(); end
                        m_mode[k] = 1;
                    end
                    1: begin
                        if (ready && !stall) begin
                            logic [31:0] t;
                            bit          r;
                            r = 1;
                            if (redir_valid)   t = live_target();
                            else if (m_has[k]) t = m_pend[k];
                            else begin t = m_pc[k] + 4; r = 0; end
                            m_has[k] = 0;
                            if (r && bad_align(t, (k == 0) ? 32 : 16)) begin
                                m_mode[k] = 2; m_bad[k] = t; m_mis[k] = 1;
                            end else begin
                                m_pc[k] = t;
                            end
                        end else if (redir_valid) begin
                            m_has[k] = 1; m_pend[k] = live_target();
                        end
                    end
                    default: begin
                        if (trap_clr) begin m_mode[k] = 1; m_pc[k] = 32'h0100_0100; m_mis[k] = 0; end
                    end
                endcase
            end
        end
    end

    always @(negedge clk) begin
        cmp("m32_pc",    pc32,  m_pc[0]);
        cmp("m32_plus4", p4_32, m_pc[0] + 4);
        cmp("m32_valid", {31'b0, fv32},  {31'b0, m_mode[0] == 1});
        cmp("m32_mis",   {31'b0, mis32}, {31'b0, m_mis[0]});
        cmp("m32_bad",   bad32, m_bad[0]);
        cmp("m16_pc",    pc16,  m_pc[1]);
        cmp("m16_plus4", p4_16, m_pc[1] + 4);
        cmp("m16_valid", {31'b0, fv16},  {31'b0, m_mode[1] == 1});
        cmp("m16_mis",   {31'b0, mis16}, {31'b0, m_mis[1]});
        cmp("m16_bad",   bad16, m_bad[1]);
    end

    initial begin
        rst_n = 1'b1; stall = 0; ready = 1; redir_valid = 0; redir_sel = 0; trap_clr = 0;
        redir_pc = 0; imm = 0; rs1 = 0;
        #1 rst_n = 1'b0;
        @(negedge clk); @(negedge clk);
        cmp("rst_pc", pc32, 32'h0100_0000);
        cmp("rst_valid", {31'b0, fv32}, 32'd0);
        cmp("rst_bad", bad32, 32'd0);
        rst_n = 1'b1;
        @(negedge clk); cmp("boot_pc0", pc32, 32'h0100_0000); cmp("boot_valid", {31'b0, fv32}, 32'd1);
        @(negedge clk); cmp("seq_pc1", pc32, 32'h0100_0004);
        @(negedge clk); cmp("seq_pc2", pc32, 32'h0100_0008);
        stall = 1;
        repeat (3) begin @(negedge clk); cmp("stall_hold", pc32, 32'h0100_0008); end
        stall = 0;
        @(negedge clk); cmp("stall_release", pc32, 32'h0100_000C);
        ready = 0; redir_valid = 1; redir_sel = 0; redir_pc = 32'h0100_0010; imm = 32'hFFFF_FFF0;
        @(negedge clk); redir_valid = 0; cmp("pend_wait", pc32, 32'h0100_000C);
        @(negedge clk); ready = 1;
        @(negedge clk); cmp("pend_apply", pc32, 32'h0100_0000);
        redir_valid = 1; redir_sel = 1; rs1 = 32'h0100_0203; imm = 0;
        @(negedge clk); redir_valid = 0;
        cmp("jalr16_pc", pc16, 32'h0100_0202);
        cmp("jalr32_mis", {31'b0, mis32}, 32'd1);
        cmp("jalr32_valid", {31'b0, fv32}, 32'd0);
        cmp("jalr32_bad", bad32, 32'h0100_0202);
        cmp("jalr32_pc_hold", pc32, 32'h0100_0000);
        trap_clr = 1;
        @(negedge clk); trap_clr = 0;
        cmp("trap_pc", pc32, 32'h0100_0100);
        cmp("trap_valid", {31'b0, fv32}, 32'd1);
        cmp("trap_mis_clr", {31'b0, mis32}, 32'd0);
        redir_valid = 1; redir_sel = 0; redir_pc = 32'h0100_0000; imm = 32'd6;
        @(negedge clk); redir_valid = 0;
        cmp("br_mis", {31'b0, mis32}, 32'd1);
        cmp("br_bad", bad32, 32'h0100_0006);
        cmp("br16_pc", pc16, 32'h0100_0006);
        #2 rst_n = 1'b0;
        #1;
        cmp("halt_rst_pc", pc32, 32'h0100_0000);
        cmp("halt_rst_mis", {31'b0, mis32}, 32'd0);
        cmp("halt_rst_bad", bad32, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); cmp("wrap_boot", pc32, 32'h0100_0000);
        redir_valid = 1; redir_sel = 0; redir_pc = 32'hFFFF_FFF0; imm = 32'h0000_000C;
        @(negedge clk); redir_valid = 0;
        cmp("wrap_top", pc32, 32'hFFFF_FFFC);
        cmp("wrap_plus4", p4_32, 32'h0000_0000);
        @(negedge clk); cmp("wrap_zero", pc32, 32'h0000_0000);

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 299) == 0) begin
                #2 rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
            stall       = ($urandom_range(0, 3) == 0);
            ready       = ($urandom_range(0, 3) != 0);
            redir_valid = ($urandom_range(0, 4) == 0);
            redir_sel   = $urandom_range(0, 1) == 1;
            trap_clr    = ($urandom_range(0, 9) == 0);
            redir_pc    = $urandom & 32'hFFFF_FFFC;
            rs1         = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            imm         = ($urandom_range(0, 5) == 0) ? $urandom : ($urandom & 32'h0000_FFFC);
        end
        redir_valid = 0; trap_clr = 0;
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
